logic_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit logic unit (AND/OR/XOR/NOR, 2-bit select) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the shared unit's a/b/select inputs from registered operands.
- Captures the unit's result and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between two client blocks and the single logic-unit instance.

---
 rtl/logic_arbiter.sv | 151 +++++++++++++++
 tb/tb_logic_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational logic unit
// (AND/OR/XOR/NOR) between two requesters. One operation is in flight at a
// time: IDLE accepts and registers operands, EXEC lets the shared unit settle
// for one cycle and captures its result, RESP holds the tagged result until
// the consumer takes it.
module logic_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             req1_ready,

    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_sel,
    input  logic [WIDTH-1:0] lu_out,

    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [1:0]       lu_sel_q, lu_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic             gnt_valid;
    logic             gnt_id;

    // Round-robin pick: a lone requester always wins, a tie goes to the one
    // that was not granted last. Only meaningful while in IDLE.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_valid && (gnt_id == 1'b0);
    assign req1_ready = gnt_valid && (gnt_id == 1'b1);

    // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        lu_a_d       = lu_a_q;
        lu_b_d       = lu_b_q;
        lu_sel_d     = lu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    lu_a_d       = gnt_id ? req1_a   : req0_a;
                    lu_b_d       = gnt_id ? req1_b   : req0_b;
                    lu_sel_d     = gnt_id ? req1_sel : req0_sel;
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable on the unit for a full cycle.
                rsp_data_d  = lu_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Data and id are left as-is after the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight op or pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            lu_sel_q     <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            lu_a_q       <= lu_a_d;
            lu_b_q       <= lu_b_d;
            lu_sel_q     <= lu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_sel    = lu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge. Every task starts and ends
// 1 ns after a rising edge.
module tb_logic_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_sel;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_sel;
    logic             req1_ready;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [1:0]       lu_sel;
    logic [WIDTH-1:0] lu_out;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    int n_cmp;
    int n_err;

    logic_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_sel  (req0_sel),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_sel  (req1_sel),
        .req1_ready(req1_ready),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_sel    (lu_sel),
        .lu_out    (lu_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    // The shared logic unit the arbiter sits in front of.
    always_comb begin
        case (lu_sel)
            2'd0:    lu_out = lu_a & lu_b;
            2'd1:    lu_out = lu_a | lu_b;
            2'd2:    lu_out = lu_a ^ lu_b;
            default: lu_out = ~(lu_a | lu_b);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = 2'd0;
        req1_a = '0; req1_b = '0; req1_sel = 2'd0;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({lu_a, lu_b, lu_sel} !== {(2*WIDTH+2){1'b0}}) begin
            n_err++;
            $display("FAIL reset_lu: got a=%h b=%h sel=%0d, want 0/0/0", lu_a, lu_b, lu_sel);
        end
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready} !== {(WIDTH+4){1'b0}}) begin
            n_err++;
            $display("FAIL reset_rsp: got v=%b d=%h id=%b r0=%b r1=%b, want all 0",
                     rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
        end
        tick();
    endtask

    // Lone requester 0: small operands on every select, then full-width patterns.
    task automatic test_lone_req0_ops;
        logic [WIDTH-1:0] va   [8];
        logic [WIDTH-1:0] vb   [8];
        logic [1:0]       vs   [8];
        logic [WIDTH-1:0] vexp [8];
        va[0] = 32'h6; vb[0] = 32'hC; vs[0] = 2'd0; vexp[0] = 32'h00000004;
        va[1] = 32'h6; vb[1] = 32'hC; vs[1] = 2'd1; vexp[1] = 32'h0000000E;
        va[2] = 32'h6; vb[2] = 32'hC; vs[2] = 2'd2; vexp[2] = 32'h0000000A;
        va[3] = 32'h6; vb[3] = 32'hC; vs[3] = 2'd3; vexp[3] = 32'hFFFFFFF1;
        va[4] = 32'hAAAAAAAA; vb[4] = 32'h55555555; vs[4] = 2'd0; vexp[4] = 32'h00000000;
        va[5] = 32'hAAAAAAAA; vb[5] = 32'h55555555; vs[5] = 2'd1; vexp[5] = 32'hFFFFFFFF;
        va[6] = 32'hAAAAAAAA; vb[6] = 32'h55555555; vs[6] = 2'd2; vexp[6] = 32'hFFFFFFFF;
        va[7] = 32'hAAAAAAAA; vb[7] = 32'h55555555; vs[7] = 2'd3; vexp[7] = 32'h00000000;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_a = va[i]; req0_b = vb[i]; req0_sel = vs[i];
            @(negedge clk);
            n_cmp++;
            if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL ops%0d_accept: got ready=%b rsp_valid=%b, want 1/0", i, req0_ready, rsp_valid);
            end
            tick();
            req0_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (req0_ready !== 1'b0 || rsp_valid !== 1'b0 || lu_a !== va[i] || lu_b !== vb[i] || lu_sel !== vs[i]) begin
                n_err++;
                $display("FAIL ops%0d_exec: got ready=%b rsp_valid=%b lu=%h/%h/%0d, want 0/0 %h/%h/%0d",
                         i, req0_ready, rsp_valid, lu_a, lu_b, lu_sel, va[i], vb[i], vs[i]);
            end
            tick();
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== vexp[i] || rsp_id !== 1'b0) begin
                n_err++;
                $display("FAIL ops%0d_rsp: got v=%b d=%h id=%b, want 1 %h 0", i, rsp_valid, rsp_data, rsp_id, vexp[i]);
            end
            $display("op req0 a=%h b=%h sel=%0d -> rsp id=%b data=%h", va[i], vb[i], vs[i], rsp_id, rsp_data);
            tick();
        end
    endtask

    // Both requesters valid continuously: grants alternate starting with 0.
    task automatic test_contention;
        logic exp_id;
        logic [WIDTH-1:0] exp_d;
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h3C; req0_sel = 2'd0;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            exp_d  = exp_id ? 32'h000000CC : 32'h00000030;
            @(negedge clk);
            n_cmp++;
            if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
                n_err++;
                $display("FAIL contend%0d_grant: got r0=%b r1=%b, want r%0d only", k, req0_ready, req1_ready, exp_id);
            end
            tick();
            @(negedge clk);
            n_cmp++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL contend%0d_exec_ready: got r0=%b r1=%b, want 0/0", k, req0_ready, req1_ready);
            end
            tick();
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== exp_id || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL contend%0d_rsp: got v=%b d=%h id=%b r0=%b r1=%b, want 1 %h %b 0 0",
                         k, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, exp_d, exp_id);
            end
            $display("contention rsp id=%b data=%h", rsp_id, rsp_data);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Response held under backpressure while requester 1 waits.
    task automatic test_backpressure;
        apply_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h6; req0_b = 32'hC; req0_sel = 2'd2;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h0F0F0F0F; req1_sel = 2'd1;
        @(negedge clk);
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_exec_ready: got r1=%b, want 0", req1_ready);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000000A || rsp_id !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h id=%b r1=%b, want 1 0000000a 0 0",
                         c, rsp_valid, rsp_data, rsp_id, req1_ready);
            end
            tick();
        end
        $display("backpressure rsp id=%b data=%h", rsp_id, rsp_data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req1_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0000000A) begin
            n_err++;
            $display("FAIL bp_release: got r1=%b v=%b d=%h, want 1 0 0000000a", req1_ready, rsp_valid, rsp_data);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFF0FFF0F || rsp_id !== 1'b1) begin
            n_err++;
            $display("FAIL bp_req1_rsp: got v=%b d=%h id=%b, want 1 ff0fff0f 1", rsp_valid, rsp_data, rsp_id);
        end
        $display("backpressure rsp id=%b data=%h", rsp_id, rsp_data);
        rsp_ready = 1'b1;
        tick();
    endtask

    // Reset in EXEC and in RESP discards the op and re-arms the tie-break.
    task automatic test_reset_midflight;
        apply_reset();
        rsp_ready = 1'b1;
        // req0 granted, so without a reset a tie would next go to req1.
        req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h0000FFFF; req0_sel = 2'd1;
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h6; req0_b = 32'hC; req0_sel = 2'd3;
        req1_valid = 1'b1; req1_a = 32'h6; req1_b = 32'hC; req1_sel = 2'd0;
        @(negedge clk);
        n_cmp++;
        if ({lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_id} !== {(3*WIDTH+4){1'b0}}) begin
            n_err++;
            $display("FAIL rst_exec_outputs: got lu=%h/%h/%0d v=%b d=%h id=%b, want all 0",
                     lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_id);
        end
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_exec_first_grant: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFF1 || rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL rst_resp_pre: got v=%b d=%h id=%b, want 1 fffffff1 0", rsp_valid, rsp_data, rsp_id);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_id} !== {(3*WIDTH+4){1'b0}}) begin
            n_err++;
            $display("FAIL rst_resp_outputs: got lu=%h/%h/%0d v=%b d=%h id=%b, want all 0",
                     lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_id);
        end
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_resp_no_delivery: got v=%b, want 0", rsp_valid);
        end
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_resp_first_grant: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        $display("reset midflight: first grant r0=%b r1=%b", req0_ready, req1_ready);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // Lone requester 1 held valid: accepted every third cycle.
    task automatic test_back_to_back;
        apply_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'h0; req1_sel = 2'd3;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req1_ready !== (c % 3 == 0) || req0_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_c%0d: got r1=%b r0=%b, want %b 0", c, req1_ready, req0_ready, (c % 3 == 0));
            end
            if (c % 3 == 2) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000000 || rsp_id !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_rsp_c%0d: got v=%b d=%h id=%b, want 1 00000000 1", c, rsp_valid, rsp_data, rsp_id);
                end
                $display("back-to-back rsp id=%b data=%h", rsp_id, rsp_data);
            end
            tick();
        end
        req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_lone_req0_ops();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
